dnc_write_heads_interface: RTL and testbench
============================================

# dnc_write_heads_interface

Responder for the DNC write-heads interface: it accepts the write-head slice of the controller interface vector ξ as an element stream and splits it into write key k, write strength β, erase vector e, write vector v, allocation gate ga and write gate gw, in DNC order. It sits between the controller output and the write-head accelerators (write key, write strength, erase vector, write vector, allocation gate, write gate), which consume its streams and scalars. Values pass through unchanged; oneplus and sigmoid stay in the downstream accelerators.

## Interface

Parameters:
- DATA_SIZE, 64, element width (fixed-point word)
- CONTROL_SIZE, 64, width of size/count fields

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse; begin parsing one ξ slice
- READY  out  1  one-cycle pulse; slice fully parsed
- SIZE_W_IN  in  CONTROL_SIZE  word size W, latched at START
- XI_IN_ENABLE  in  1  XI_IN valid this cycle
- XI_IN  in  DATA_SIZE  ξ element
- XI_OUT_ENABLE  out  1  block can accept an element this cycle
- K_OUT_ENABLE  out  1  K_OUT valid (one cycle per element)
- K_OUT  out  DATA_SIZE  write key element
- BETA_OUT  out  DATA_SIZE  write strength, held until next START
- E_OUT_ENABLE  out  1  E_OUT valid
- E_OUT  out  DATA_SIZE  erase vector element
- V_OUT_ENABLE  out  1  V_OUT valid
- V_OUT  out  DATA_SIZE  write vector element
- GA_OUT  out  DATA_SIZE  allocation gate, held
- GW_OUT  out  DATA_SIZE  write gate, held

## Operation

- Reset value of every output: 0. FSM goes to IDLE and the index counter is cleared.
- The block is a single FSM: IDLE → KEY → BETA → ERASE → VECTOR → GA → GW → DONE → IDLE.
- IDLE: on START=1, latch SIZE_W_IN into w_reg, clear index, then go to KEY. If w_reg=0, go to BETA instead.
- Loading states (KEY, BETA, ERASE, VECTOR, GA, GW):
  - XI_OUT_ENABLE=1 throughout.
  - An element is accepted on any cycle with XI_IN_ENABLE=1.
  - Bubbles (XI_IN_ENABLE=0) stall the FSM without limit.
- Vector states (KEY, ERASE, VECTOR):
  - Each accepted element drives the state's *_OUT with its *_OUT_ENABLE for exactly one cycle.
  - The index increments on each accepted element.
  - When index reaches w_reg-1 on an accept, the index clears and the FSM advances. From VECTOR it advances to GA.
  - If w_reg=0, ERASE and VECTOR are skipped: BETA→GA.
- Scalar states (BETA, GA, GW): one accepted element loads the held register (BETA_OUT, GA_OUT, GW_OUT) and the FSM advances.
  - BETA goes to ERASE, or to GA if w_reg=0.
- DONE: READY=1 for one cycle, then IDLE.
- Held scalars keep their value until overwritten in the next slice; START does not clear them.
- Total accepted elements per slice: 3·w_reg+3.
- Index counter is CONTROL_SIZE wide; w_reg is unsigned.
- Ignored inputs:
  - START while not in IDLE.
  - XI_IN_ENABLE in IDLE or DONE. XI_OUT_ENABLE=0 in these states.
- RST mid-slice aborts immediately. No READY is issued, all outputs return to 0, and the partial slice is discarded.
- RST and START asserted together: reset wins.

## Timing

- START sampled at edge t. XI_OUT_ENABLE=1 from cycle t+1.
- Element accepted at edge t:
  - Matching *_OUT / *_OUT_ENABLE, or the held scalar, is valid in cycle t+1 (one-cycle registered latency).
  - The FSM state updates at edge t, so back-to-back acceptance is possible every cycle.
- Last element (gw) accepted at edge t: GW_OUT is updated in t+1 and READY=1 in t+1.
- READY and the final GW_OUT update coincide.
- With no bubbles, START to READY is 3·w_reg+4 cycles. XI_OUT_ENABLE=0 during the READY cycle.
- Earliest next START: the cycle after READY. A START in the READY cycle itself is ignored.
- Enables are never asserted in IDLE. There is never more than one *_OUT_ENABLE high in a cycle.

## Test plan

- **Reset.** Hold RST 2 cycles. All outputs and XI_OUT_ENABLE must be 0. Then a START pulse with XI_IN_ENABLE=0 must give XI_OUT_ENABLE=1 from the next cycle.
- **Nominal W=4.** Feed elements 1..15 every cycle.
  - K_OUT: 1,2,3,4. E_OUT: 6..9. V_OUT: 10..13.
  - BETA_OUT=5, GA_OUT=14, GW_OUT=15.
  - Each enable is high for exactly 4 cycles. READY pulses once, 16 cycles after START.
- **Bubbles.** W=2; drop XI_IN_ENABLE on every other cycle while feeding 1..9.
  - Same field mapping: k=1,2; β=3; e=4,5; v=6,7; ga=8; gw=9.
  - READY comes 1 cycle after element 9 is accepted.
- **W=0.** Feed 7,8,9. Result: BETA_OUT=7, GA_OUT=8, GW_OUT=9. No K/E/V enables are ever asserted. READY 4 cycles after START.
- **Ignored inputs.** W=3. Pulse START again mid-KEY, and assert XI_IN_ENABLE in IDLE before START. Neither may perturb the sequence or the counts.
- **Reset mid-slice.** W=4; assert RST during ERASE.
  - No READY; outputs return to 0.
  - A following clean slice fed 21..35 yields BETA_OUT=25, GA_OUT=34, GW_OUT=35.

Source files
------------

// File: rtl/dnc_write_heads_interface.sv
// dnc_write_heads_interface: splits the write-head slice of xi into k, beta, e, v, ga, gw.
module dnc_write_heads_interface #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
    input  logic                    XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    XI_IN,
    output logic                    XI_OUT_ENABLE,
    output logic                    K_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    K_OUT,
    output logic [DATA_SIZE-1:0]    BETA_OUT,
    output logic                    E_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    E_OUT,
    output logic                    V_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    V_OUT,
    output logic [DATA_SIZE-1:0]    GA_OUT,
    output logic [DATA_SIZE-1:0]    GW_OUT
);
    typedef enum logic [2:0] {IDLE, KEY, BETA, ERASE, VECTOR, GA, GW, DONE} state_t;
    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] w_q, w_d, idx_q, idx_d;
    logic                    k_en_q, k_en_d, e_en_q, e_en_d, v_en_q, v_en_d;
    logic [DATA_SIZE-1:0]    k_q, k_d, e_q, e_d, v_q, v_d;
    logic [DATA_SIZE-1:0]    beta_q, beta_d, ga_q, ga_d, gw_q, gw_d;
    logic                    loading, acc, last, vec_state;
    assign loading   = state_q != IDLE && state_q != DONE;
    assign acc       = loading && XI_IN_ENABLE;
    assign last      = idx_q == w_q - CONTROL_SIZE'(1);
    assign vec_state = state_q == KEY || state_q == ERASE || state_q == VECTOR;
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = (acc && vec_state) ? (last ? '0 : idx_q + CONTROL_SIZE'(1)) : idx_q;
        k_en_d  = 1'b0;
        e_en_d  = 1'b0;
        v_en_d  = 1'b0;
        k_d     = k_q;
        e_d     = e_q;
        v_d     = v_q;
        beta_d  = beta_q;
        ga_d    = ga_q;
        gw_d    = gw_q;
        case (state_q)
            IDLE: if (START) begin
                w_d     = SIZE_W_IN;
                idx_d   = '0;
                state_d = (SIZE_W_IN == '0) ? BETA : KEY;
            end
            KEY: if (acc) begin
                k_en_d  = 1'b1;
                k_d     = XI_IN;
                state_d = last ? BETA : KEY;
            end
            BETA: if (acc) begin
                beta_d  = XI_IN;
                state_d = (w_q == '0) ? GA : ERASE;
            end
            ERASE: if (acc) begin
                e_en_d  = 1'b1;
                e_d     = XI_IN;
                state_d = last ? VECTOR : ERASE;
            end
            VECTOR: if (acc) begin
                v_en_d  = 1'b1;
                v_d     = XI_IN;
                state_d = last ? GA : VECTOR;
            end
            GA: if (acc) begin
                ga_d    = XI_IN;
                state_d = GW;
            end
            GW: if (acc) begin
                gw_d    = XI_IN;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            w_q     <= '0;
            idx_q   <= '0;
            k_en_q  <= 1'b0;
            e_en_q  <= 1'b0;
            v_en_q  <= 1'b0;
            k_q     <= '0;
            e_q     <= '0;
            v_q     <= '0;
            beta_q  <= '0;
            ga_q    <= '0;
            gw_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            k_en_q  <= k_en_d;
            e_en_q  <= e_en_d;
            v_en_q  <= v_en_d;
            k_q     <= k_d;
            e_q     <= e_d;
            v_q     <= v_d;
            beta_q  <= beta_d;
            ga_q    <= ga_d;
            gw_q    <= gw_d;
        end
    end
    assign READY         = state_q == DONE;
    assign XI_OUT_ENABLE = loading;
    assign K_OUT_ENABLE  = k_en_q;
    assign E_OUT_ENABLE  = e_en_q;
    assign V_OUT_ENABLE  = v_en_q;
    assign K_OUT         = k_q;
    assign E_OUT         = e_q;
    assign V_OUT         = v_q;
    assign BETA_OUT      = beta_q;
    assign GA_OUT        = ga_q;
    assign GW_OUT        = gw_q;
endmodule

// File: tb/tb_dnc_write_heads_interface.sv
// tb_dnc_write_heads_interface: directed slice vectors plus reset and abort sequences.
module tb_dnc_write_heads_interface;
    logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, XI_IN_ENABLE = 1'b0;
    logic [63:0] SIZE_W_IN = '0, XI_IN = '0;
    logic        READY, XI_OUT_ENABLE, K_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE;
    logic [63:0] K_OUT, BETA_OUT, E_OUT, V_OUT, GA_OUT, GW_OUT;
    int          checks = 0, failures = 0, cyc = 0, ready_cnt = 0;
    bit          multi = 1'b0;
    logic [63:0] kq[$], eq[$], vq[$];

    dnc_write_heads_interface #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_W_IN(SIZE_W_IN),
        .XI_IN_ENABLE(XI_IN_ENABLE), .XI_IN(XI_IN), .XI_OUT_ENABLE(XI_OUT_ENABLE),
        .K_OUT_ENABLE(K_OUT_ENABLE), .K_OUT(K_OUT), .BETA_OUT(BETA_OUT),
        .E_OUT_ENABLE(E_OUT_ENABLE), .E_OUT(E_OUT), .V_OUT_ENABLE(V_OUT_ENABLE),
        .V_OUT(V_OUT), .GA_OUT(GA_OUT), .GW_OUT(GW_OUT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (K_OUT_ENABLE) kq.push_back(K_OUT);
        if (E_OUT_ENABLE) eq.push_back(E_OUT);
        if (V_OUT_ENABLE) vq.push_back(V_OUT);
        if (int'(K_OUT_ENABLE) + int'(E_OUT_ENABLE) + int'(V_OUT_ENABLE) > 1) multi = 1'b1;
        if (READY) ready_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_xoe"}, {63'd0, XI_OUT_ENABLE}, 0);
        chk({tag, "_ready"}, {63'd0, READY}, 0);
        chk({tag, "_en"}, {61'd0, K_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE}, 0);
        chk({tag, "_k"}, K_OUT, 0);
        chk({tag, "_e"}, E_OUT, 0);
        chk({tag, "_v"}, V_OUT, 0);
        chk({tag, "_beta"}, BETA_OUT, 0);
        chk({tag, "_ga"}, GA_OUT, 0);
        chk({tag, "_gw"}, GW_OUT, 0);
    endtask

    typedef struct {
        int          w;
        int          base;
        bit          bub;
        bit          ign;
        logic [63:0] beta, ga, gw;
        int          lat;
    } vec_t;

    task automatic run_slice(input vec_t v, input int idx);
        int  s, last_acc, rdy_at, n;
        bit  got;
        logic [63:0] gw_r;
        logic xoe_r;
        string t;
        t = $sformatf("slice%0d", idx);
        kq.delete(); eq.delete(); vq.delete();
        ready_cnt = 0; multi = 1'b0; got = 1'b0; rdy_at = -1; gw_r = '0; xoe_r = 1'b0;
        if (v.ign) begin
            XI_IN_ENABLE = 1'b1; XI_IN = 64'd99;
            repeat (2) tick();
        end
        XI_IN_ENABLE = 1'b0;
        START = 1'b1; SIZE_W_IN = 64'(v.w);
        tick();
        s = cyc; START = 1'b0;
        n = 3 * v.w + 3;
        for (int i = 0; i < n; i++) begin
            if (v.bub && i > 0) begin
                XI_IN_ENABLE = 1'b0;
                tick();
            end
            XI_IN_ENABLE = 1'b1; XI_IN = 64'(v.base + i);
            START = v.ign && i == 1;
            tick();
            last_acc = cyc; START = 1'b0;
        end
        XI_IN_ENABLE = 1'b0;
        for (int j = 0; j < 20 && !got; j++) begin
            @(negedge CLK);
            if (READY) begin
                got = 1'b1; rdy_at = cyc; gw_r = GW_OUT; xoe_r = XI_OUT_ENABLE;
            end
        end
        chk({t, "_ready_seen"}, {63'd0, got}, 1);
        chk({t, "_ready_after_gw"}, 64'(rdy_at), 64'(last_acc));
        if (v.lat != 0) chk({t, "_latency"}, 64'(rdy_at - s + 1), 64'(v.lat));
        chk({t, "_gw_at_ready"}, gw_r, v.gw);
        chk({t, "_xoe_at_ready"}, {63'd0, xoe_r}, 0);
        repeat (3) tick();
        chk({t, "_ready_pulses"}, 64'(ready_cnt), 1);
        chk({t, "_multi_en"}, {63'd0, multi}, 0);
        chk({t, "_beta"}, BETA_OUT, v.beta);
        chk({t, "_ga"}, GA_OUT, v.ga);
        chk({t, "_gw"}, GW_OUT, v.gw);
        chk({t, "_k_cnt"}, 64'(kq.size()), 64'(v.w));
        chk({t, "_e_cnt"}, 64'(eq.size()), 64'(v.w));
        chk({t, "_v_cnt"}, 64'(vq.size()), 64'(v.w));
        for (int i = 0; i < v.w && i < kq.size(); i++) chk({t, "_k"}, kq[i], 64'(v.base + i));
        for (int i = 0; i < v.w && i < eq.size(); i++) chk({t, "_e"}, eq[i], 64'(v.base + v.w + 1 + i));
        for (int i = 0; i < v.w && i < vq.size(); i++) chk({t, "_v"}, vq[i], 64'(v.base + 2 * v.w + 1 + i));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{w: 4, base: 21, bub: 0, ign: 0, beta: 25, ga: 34, gw: 35, lat: 16};
        vecs[1] = '{w: 4, base: 1,  bub: 0, ign: 0, beta: 5,  ga: 14, gw: 15, lat: 16};
        vecs[2] = '{w: 2, base: 1,  bub: 1, ign: 0, beta: 3,  ga: 8,  gw: 9,  lat: 0};
        vecs[3] = '{w: 0, base: 7,  bub: 0, ign: 0, beta: 7,  ga: 8,  gw: 9,  lat: 4};
        vecs[4] = '{w: 3, base: 1,  bub: 0, ign: 1, beta: 4,  ga: 11, gw: 12, lat: 13};

        repeat (2) tick();
        chk_all_zero("rst_held");
        RST = 1'b0;
        tick();
        chk_all_zero("rst_released");
        START = 1'b1; SIZE_W_IN = 64'd4;
        tick();
        START = 1'b0;
        chk("start_xoe", {63'd0, XI_OUT_ENABLE}, 1);
        repeat (3) tick();
        chk("stall_xoe", {63'd0, XI_OUT_ENABLE}, 1);
        chk("stall_k_en", {63'd0, K_OUT_ENABLE}, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;

        ready_cnt = 0;
        START = 1'b1; SIZE_W_IN = 64'd4;
        tick();
        START = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            XI_IN_ENABLE = 1'b1; XI_IN = 64'(i);
            tick();
        end
        XI_IN_ENABLE = 1'b0;
        chk("abort_pre_e", E_OUT, 7);
        chk("abort_pre_beta", BETA_OUT, 5);
        RST = 1'b1;
        tick();
        chk_all_zero("abort_rst");
        RST = 1'b0;
        repeat (5) tick();
        chk("abort_no_ready", 64'(ready_cnt), 0);
        chk("abort_idle_xoe", {63'd0, XI_OUT_ENABLE}, 0);

        foreach (vecs[i]) run_slice(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
